pipe_skid_reg: RTL

Parametrised pipeline stage register with valid/ready handshaking, a 2-entry skid buffer, synchronous flush and a saturating back-pressure counter. It replaces per-stage hand-written enable/flush registers between datapath stages: the upstream stage packs its fields into one `WIDTH`-bit payload, and the downstream stage unpacks them. It sustains one transfer per cycle. `in_ready` is fully registered, so downstream stalls never form a combinational path back to upstream.

---
 rtl/pipe_skid_reg.sv | 106 ++++++++++
 1 files changed

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, a 2-entry skid buffer,
// synchronous flush and a saturating back-pressure (stall) counter.
//
// state | meaning
// EMPTY | no entry held; out_valid low, main holds RESET_VAL
// ONE   | head entry in main; skid unused
// TWO   | head in main, next entry in skid; in_ready low
module pipe_skid_reg #(
  parameter int unsigned           WIDTH     = 32,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0,
  parameter int unsigned           CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] main_q, main_nxt;
  logic [WIDTH-1:0] skid_q, skid_nxt;
  logic [CNT_W-1:0] stall_q;
  logic             push, pop;

  // in_ready comes straight from the state register so no downstream path reaches upstream
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state;
  assign stall_cnt = stall_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
      stall_q <= '0;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
      if (!flush && out_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
        stall_q <= stall_q + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush) begin
      state_nxt = EMPTY;
      main_nxt  = RESET_VAL;
      skid_nxt  = RESET_VAL;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            main_nxt  = in_data;
            state_nxt = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_nxt = in_data;
          end else if (push) begin
            skid_nxt  = in_data;
            state_nxt = TWO;
          end else if (pop) begin
            main_nxt  = RESET_VAL;
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            main_nxt  = skid_q;
            skid_nxt  = RESET_VAL;
            state_nxt = ONE;
          end
        end
        default: begin
          state_nxt = EMPTY;
          main_nxt  = RESET_VAL;
          skid_nxt  = RESET_VAL;
        end
      endcase
    end
  end

endmodule
